// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction width, opcode field and the
// fetch-stage FSM encoding used by the front end.
package isa_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 12;

   localparam logic [3:0] OPCODE_LOAD  = 4'h9;
   localparam logic [3:0] OPCODE_STORE = 4'hA;
   localparam logic [3:0] OPCODE_HALT  = 4'hF;

   localparam logic [0:0] FETCH_RUN  = 1'b0;
   localparam logic [0:0] FETCH_HALT = 1'b1;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency ROM and
// registers the returned instruction for the decoder.
module fetch_unit
   import isa_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [15:0]        imem_rdata,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [15:0]        instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   output logic               halted
);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic               req_v_q, req_v_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
   logic               instr_valid_q, instr_valid_d;
   logic [0:0]         state_q, state_d;

   logic hold;
   logic run;

   assign hold = stall & instr_valid_q;
   assign run  = (state_q == FETCH_RUN);

   // While holding, the response arriving now is discarded, so the same
   // address is re-issued and arrives again once the decoder accepts.
   always_comb begin
      if (!run) begin
         imem_addr = pc_q;
      end else if (redirect_valid) begin
         imem_addr = redirect_pc;
      end else if (hold) begin
         imem_addr = req_pc_q;
      end else begin
         imem_addr = pc_q;
      end
   end

   always_comb begin
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      req_v_d       = req_v_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      state_d       = state_q;

      if (run) begin
         req_pc_d = imem_addr;
         req_v_d  = 1'b1;
         pc_d     = imem_addr + ADDR_W'(1);

         if (redirect_valid) begin
            instr_valid_d = 1'b0;
         end else if (!hold) begin
            instr_d       = imem_rdata;
            instr_pc_d    = req_pc_q;
            instr_valid_d = req_v_q;
            if (req_v_q && (opcode_of(imem_rdata) == OPCODE_HALT)) begin
               state_d = FETCH_HALT;
            end
         end
      end else begin
         // Halted: keep presenting the HALT word until it is accepted.
         req_v_d = 1'b0;
         if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         req_pc_q      <= '0;
         req_v_q       <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         state_q       <= FETCH_RUN;
      end else begin
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         req_v_q       <= req_v_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         state_q       <= state_d;
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0 and 0xFE) share stimulus
// and are checked against an instruction-stream reference model.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = '0;

   logic [7:0]  addr0, addr1, ipc0, ipc1;
   logic [15:0] rdata0, rdata1, instr0, instr1;
   logic        iv0, iv1, hl0, hl1;

   logic [15:0] rom [2][256];

   int checks = 0;
   int errors = 0;

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut0 (
      .clk(clk), .rst(rst), .imem_addr(addr0), .imem_rdata(rdata0),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr(instr0), .instr_pc(ipc0), .instr_valid(iv0), .halted(hl0)
   );

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) dut1 (
      .clk(clk), .rst(rst), .imem_addr(addr1), .imem_rdata(rdata1),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr(instr1), .instr_pc(ipc1), .instr_valid(iv1), .halted(hl1)
   );

   always @(posedge clk) begin
      rdata0 <= rom[0][addr0];
      rdata1 <= rom[1][addr1];
   end

   // Reference model: the instruction stream each instance should deliver.
   logic [7:0]  m_start [2] = '{8'h00, 8'hFE};
   bit          m_v     [2];
   bit          m_fill  [2];
   bit          m_halt  [2];
   logic [7:0]  m_pc    [2];
   logic [7:0]  m_next  [2];
   logic [15:0] m_instr [2];
   bit          m_was_rst;

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_v[k] = 0; m_fill[k] = 1; m_halt[k] = 0;
            m_pc[k] = 8'h00; m_instr[k] = 16'h0000; m_next[k] = m_start[k];
         end else if (m_halt[k]) begin
            if (m_v[k] && !stall) m_v[k] = 0;
         end else if (redirect_valid) begin
            m_v[k] = 0; m_fill[k] = 0; m_next[k] = redirect_pc;
         end else if (stall && m_v[k]) begin
            // decoder busy: nothing moves
         end else if (m_fill[k]) begin
            m_v[k] = 0; m_fill[k] = 0;
         end else begin
            m_v[k] = 1;
            m_pc[k] = m_next[k];
            m_instr[k] = rom[k][m_next[k]];
            m_next[k] = m_next[k] + 8'd1;
            if (m_instr[k][15:12] == 4'hF) m_halt[k] = 1;
         end
      end
      m_was_rst = rst;
   endtask

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s[dut%0d] observed %h expected %h", tag, k, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("valid", 0, 32'(iv0), 32'(m_v[0]));
      check("halted", 0, 32'(hl0), 32'(m_halt[0]));
      check("valid", 1, 32'(iv1), 32'(m_v[1]));
      check("halted", 1, 32'(hl1), 32'(m_halt[1]));
      if (m_v[0] || m_was_rst) begin
         check("instr", 0, 32'(instr0), 32'(m_instr[0]));
         check("instr_pc", 0, 32'(ipc0), 32'(m_pc[0]));
      end
      if (m_v[1] || m_was_rst) begin
         check("instr", 1, 32'(instr1), 32'(m_instr[1]));
         check("instr_pc", 1, 32'(ipc1), 32'(m_pc[1]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed timeout expected event", tag);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[0][i] = 16'h1000 + 16'(i);
         rom[1][i] = 16'h2000 + 16'(i);
      end

      // reset state
      rst = 1;
      cycle();
      cycle();
      check("rst_valid", 0, 32'(iv0), 32'h0);
      check("rst_instr", 0, 32'(instr0), 32'h0);

      // reset release: first valid on the second edge, wrap for dut1
      rst = 0;
      cycle();
      check("fill_valid", 0, 32'(iv0), 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("seq_instr", 0, 32'(instr0), 32'h1000 + 32'(i));
         check("seq_pc", 0, 32'(ipc0), 32'(i));
         check("wrap_pc", 1, 32'(ipc1), 32'(8'(8'hFE + 8'(i))));
      end

      // three-cycle stall on 0x1003, then 0x1004 with no skip
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_pc", 0, 32'(ipc0), 32'h3);
         check("stall_instr", 0, 32'(instr0), 32'h1003);
      end
      stall = 0;
      cycle();
      check("post_stall", 0, 32'(instr0), 32'h1004);

      // redirect beats stall; one bubble then the target
      stall = 1; redirect_valid = 1; redirect_pc = 8'h40;
      cycle();
      check("redir_bubble", 0, 32'(iv0), 32'h0);
      redirect_valid = 0;
      cycle();
      check("redir_pc", 0, 32'(ipc0), 32'h40);
      check("redir_instr", 0, 32'(instr0), 32'h1040);
      stall = 0;

      // randomized stall/redirect traffic
      for (int n = 0; n < 300; n++) begin
         stall = ($urandom_range(0, 2) == 0);
         redirect_valid = ($urandom_range(0, 7) == 0);
         redirect_pc = 8'($urandom_range(0, 255));
         cycle();
      end
      redirect_valid = 0;

      // mid-stream reset while stalled
      stall = 1; rst = 1;
      cycle();
      check("midrst_valid", 0, 32'(iv0), 32'h0);
      check("midrst_pc", 0, 32'(ipc0), 32'h0);
      rst = 0; stall = 0;
      cycle();
      cycle();
      check("restart_pc", 0, 32'(ipc0), 32'h0);
      check("restart_valid", 0, 32'(iv0), 32'h1);

      // HALT word at address 5
      rom[0][5] = 16'hF000;
      begin
         int n = 0;
         while (!(m_v[0] && m_pc[0] == 8'h05) && n < 40) begin
            cycle();
            n++;
         end
         if (!(m_v[0] && m_pc[0] == 8'h05)) timeout("reach_halt");
      end
      check("halt_flag", 0, 32'(hl0), 32'h1);
      stall = 1;
      cycle();
      cycle();
      check("halt_held", 0, 32'(instr0), 32'hF000);
      check("halt_held_v", 0, 32'(iv0), 32'h1);
      stall = 0;
      cycle();
      check("halt_accept", 0, 32'(iv0), 32'h0);
      redirect_valid = 1; redirect_pc = 8'h80;
      cycle();
      redirect_valid = 0;
      for (int i = 0; i < 4; i++) cycle();
      check("halt_ignore_redir", 0, 32'(iv0), 32'h0);
      check("halt_stays", 0, 32'(hl0), 32'h1);

      // reset leaves HALT; redirect coincident with the HALT word wins
      rst = 1;
      cycle();
      rst = 0;
      begin
         int n = 0;
         while (m_next[0] != 8'h05 && n < 20) begin
            cycle();
            n++;
         end
         if (m_next[0] != 8'h05) timeout("reach_5");
      end
      redirect_valid = 1; redirect_pc = 8'h20;
      cycle();
      redirect_valid = 0;
      check("coinc_no_halt", 0, 32'(hl0), 32'h0);
      cycle();
      check("coinc_target", 0, 32'(instr0), 32'h1020);
      for (int i = 0; i < 5; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
